// File: rtl/sertx_pkg.sv
// sertx_pkg: shared constants for the serial transmitter slice.
//   SERTX_IDLE / SERTX_SHIFT : FSM state encodings
//   SERTX_WIDTH              : default word width
// Optional build macro used by sertx: SERTX_LSB_FIRST_EN (LSB-first shifting).
package sertx_pkg;

  typedef logic [0:0] sertx_state_t;

  localparam sertx_state_t SERTX_IDLE  = 1'b0;
  localparam sertx_state_t SERTX_SHIFT = 1'b1;

  localparam int SERTX_WIDTH = 16;

endpackage

// File: rtl/sertx_hold.sv
// sertx_hold: one-word holding buffer in front of the shifter, plus the
// sticky overrun flag.
// Ports:
//   clk_i     system clock
//   resl_i    synchronous active-low reset
//   ld_i      write strobe, samples din_i
//   din_i     parallel write data
//   xfer_i    shifter is taking the held word this cycle
//   ovrclr_i  clears the overrun flag
//   hold_o    held word
//   hfull_o   buffer holds an untransmitted word
//   ovr_o     sticky overrun (write dropped while full)
module sertx_hold
  import sertx_pkg::*;
#(
  parameter int WIDTH = SERTX_WIDTH
) (
  input  logic             clk_i,
  input  logic             resl_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             xfer_i,
  input  logic             ovrclr_i,
  output logic [WIDTH-1:0] hold_o,
  output logic             hfull_o,
  output logic             ovr_o
);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hfull_q, hfull_d;
  logic             ovr_q, ovr_d;
  logic             accept;
  logic             drop;

  // A write is taken when the buffer is empty or is being emptied in the
  // same cycle; the old word has already been copied into the shifter.
  assign accept = ld_i & (~hfull_q | xfer_i);
  assign drop   = ld_i & hfull_q & ~xfer_i;

  always_comb begin
    hold_d  = hold_q;
    hfull_d = hfull_q;
    ovr_d   = ovr_q;
    if (accept) begin
      hold_d  = din_i;
      hfull_d = 1'b1;
    end else if (xfer_i) begin
      hfull_d = 1'b0;
    end
    // A new overrun beats a clear arriving in the same cycle.
    if (drop) begin
      ovr_d = 1'b1;
    end else if (ovrclr_i) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resl_i) begin
      hold_q  <= '0;
      hfull_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      hfull_q <= hfull_d;
      ovr_q   <= ovr_d;
    end
  end

  assign hold_o  = hold_q;
  assign hfull_o = hfull_q;
  assign ovr_o   = ovr_q;

endmodule

// File: rtl/sertx.sv
// sertx: parallel-to-serial transmitter with a one-word holding buffer.
// A written word is shifted out one bit per en_i strobe, MSB first, with
// frame_o high during the first bit. A word waiting in the holding buffer
// is reloaded on the last bit's en_i with no gap bit.
// Build macro: SERTX_LSB_FIRST_EN -- when defined, words go out LSB first.
// Ports:
//   clk_i     system clock
//   resl_i    synchronous active-low reset
//   din_i     parallel write data
//   ld_i      write strobe
//   en_i      bit-rate enable, one shift per asserted cycle
//   ovrclr_i  clears overrun flag
//   sdo_o     serial data out (registered)
//   frame_o   first bit of each word (registered)
//   busy_o    shifter active
//   hempty_o  holding buffer empty (interrupt request)
//   ovr_o     sticky overrun
//
// state  | meaning
// IDLE   | nothing on the line, sdo low, waiting for a held word and en
// SHIFT  | a word is on the line; cnt = bits still to follow the current one
module sertx
  import sertx_pkg::*;
#(
  parameter int WIDTH = SERTX_WIDTH
) (
  input  logic             clk_i,
  input  logic             resl_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             ld_i,
  input  logic             en_i,
  input  logic             ovrclr_i,
  output logic             sdo_o,
  output logic             frame_o,
  output logic             busy_o,
  output logic             hempty_o,
  output logic             ovr_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sertx_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sdo_q, sdo_d;
  logic             frame_q, frame_d;

  logic [WIDTH-1:0] hold;
  logic             hfull;
  logic             ovr;
  logic             cnt_zero;
  logic             xfer;

  logic             load_bit;
  logic [WIDTH-1:0] load_shreg;
  logic             shift_bit;
  logic [WIDTH-1:0] shift_shreg;

`ifdef SERTX_LSB_FIRST_EN
  assign load_bit    = hold[0];
  assign load_shreg  = {1'b0, hold[WIDTH-1:1]};
  assign shift_bit   = shreg_q[0];
  assign shift_shreg = {1'b0, shreg_q[WIDTH-1:1]};
`else
  assign load_bit    = hold[WIDTH-1];
  assign load_shreg  = {hold[WIDTH-2:0], 1'b0};
  assign shift_bit   = shreg_q[WIDTH-1];
  assign shift_shreg = {shreg_q[WIDTH-2:0], 1'b0};
`endif

  assign cnt_zero = (cnt_q == '0);

  // The shifter can take the held word when idle or while its last bit is
  // on the line.
  assign xfer = en_i & hfull & ((state_q == SERTX_IDLE) |
                                ((state_q == SERTX_SHIFT) & cnt_zero));

  sertx_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk_i   (clk_i),
    .resl_i  (resl_i),
    .ld_i    (ld_i),
    .din_i   (din_i),
    .xfer_i  (xfer),
    .ovrclr_i(ovrclr_i),
    .hold_o  (hold),
    .hfull_o (hfull),
    .ovr_o   (ovr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sdo_d   = sdo_q;
    frame_d = frame_q;
    case (state_q)
      SERTX_IDLE: begin
        if (xfer) begin
          sdo_d   = load_bit;
          shreg_d = load_shreg;
          cnt_d   = CNT_LAST;
          frame_d = 1'b1;
          state_d = SERTX_SHIFT;
        end else begin
          sdo_d   = 1'b0;
          frame_d = 1'b0;
        end
      end
      SERTX_SHIFT: begin
        if (en_i) begin
          if (!cnt_zero) begin
            sdo_d   = shift_bit;
            shreg_d = shift_shreg;
            cnt_d   = cnt_q - 1'b1;
            frame_d = 1'b0;
          end else if (hfull) begin
            sdo_d   = load_bit;
            shreg_d = load_shreg;
            cnt_d   = CNT_LAST;
            frame_d = 1'b1;
          end else begin
            sdo_d   = 1'b0;
            frame_d = 1'b0;
            state_d = SERTX_IDLE;
          end
        end
      end
      default: begin
        state_d = SERTX_IDLE;
        sdo_d   = 1'b0;
        frame_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resl_i) begin
      state_q <= SERTX_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sdo_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sdo_q   <= sdo_d;
      frame_q <= frame_d;
    end
  end

  assign sdo_o    = sdo_q;
  assign frame_o  = frame_q;
  assign busy_o   = (state_q == SERTX_SHIFT);
  assign hempty_o = ~hfull;
  assign ovr_o    = ovr;

endmodule

// File: tb/tb_sertx.sv
// tb_sertx: randomized and directed stimulus for sertx, checked every cycle
// against a word/bit-position model, plus literal expectations on the
// serial streams of the directed scenarios.
module tb_sertx;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         resl;
  logic [W-1:0] din;
  logic         ld, en, ovrclr;
  logic         sdo, frame, busy, hempty, ovr;

  int tests = 0;
  int fails = 0;

  logic [63:0] cap;
  logic [63:0] frc;

  always #5 clk = ~clk;

  sertx #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .resl_i  (resl),
    .din_i   (din),
    .ld_i    (ld),
    .en_i    (en),
    .ovrclr_i(ovrclr),
    .sdo_o   (sdo),
    .frame_o (frame),
    .busy_o  (busy),
    .hempty_o(hempty),
    .ovr_o   (ovr)
  );

  // Bit 'pos' of the transmission order of word w.
  function automatic bit word_bit(logic [W-1:0] w, int pos);
`ifdef SERTX_LSB_FIRST_EN
    return w[pos];
`else
    return w[W-1-pos];
`endif
  endfunction

  // Word as it appears in the captured stream (first bit in the MSB).
  function automatic logic [W-1:0] ord(logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[W-1-i] = word_bit(w, i);
    return r;
  endfunction

  // Model: a held word, the word on the line and how many bit periods of it
  // remain (0 = line idle).
  logic [W-1:0] m_hold, m_cur;
  bit           m_hfull, m_ovr, m_sdo, m_frame;
  int           m_left, m_pos;
  bit           started = 1'b0;

  always @(posedge clk) begin
    bit start, dropped;
    started = 1'b1;
    if (!resl) begin
      m_hold = '0; m_cur = '0; m_hfull = 0; m_ovr = 0;
      m_sdo = 0; m_frame = 0; m_left = 0; m_pos = 0;
    end else begin
      start   = en && m_hfull && (m_left <= 1);
      dropped = ld && m_hfull && !start;
      if (start) begin
        m_cur = m_hold; m_pos = 0; m_left = W;
        m_sdo = word_bit(m_cur, 0); m_frame = 1;
      end else if (en && m_left > 1) begin
        m_pos++; m_left--;
        m_sdo = word_bit(m_cur, m_pos); m_frame = 0;
      end else if (en || m_left == 0) begin
        m_left = 0; m_sdo = 0; m_frame = 0;
      end
      if (ld && !dropped) begin
        m_hold = din; m_hfull = 1;
      end else if (start) begin
        m_hfull = 0;
      end
      if (dropped) m_ovr = 1;
      else if (ovrclr) m_ovr = 0;
    end
  end

  always @(negedge clk) begin
    logic [4:0] a, e;
    if (started) begin
      a = {sdo, frame, busy, hempty, ovr};
      e = {m_sdo, m_frame, (m_left != 0), !m_hfull, m_ovr};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL model_cmp t=%0t sdo,frame,busy,hempty,ovr got %b want %b", $time, a, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit l, input logic [W-1:0] d, input bit e, input bit oc = 1'b0);
    ld = l; din = d; en = e; ovrclr = oc;
    @(posedge clk); #1;
    if (e) begin
      cap = {cap[62:0], sdo};
      frc = {frc[62:0], frame};
    end
    ld = 1'b0; en = 1'b0; ovrclr = 1'b0;
  endtask

  initial begin
    logic [W-1:0] t;
    resl = 1'b0; ld = 1'b0; en = 1'b0; ovrclr = 1'b0; din = '0;
    cap = '0; frc = '0;

    // Reset with ld and en active.
    repeat (2) cyc(1'b1, 16'hAAAA, 1'b1);
    chk("reset_state", {59'd0, sdo, frame, busy, hempty, ovr}, 64'b00010);
    resl = 1'b1;
    cyc(0, '0, 0);

    // Single word, en every 4th clock.
    cyc(1, 16'hA5C3, 0);
    cap = '0; frc = '0;
    repeat (16) begin
      repeat (3) cyc(0, '0, 0);
      cyc(0, '0, 1);
    end
    chk("single_bits", cap[15:0], ord(16'hA5C3));
    chk("single_frame", frc[15:0], 16'h8000);
    repeat (3) cyc(0, '0, 0);
    cyc(0, '0, 1);
    chk("single_end", {62'd0, busy, sdo}, 64'd0);

    // Back-to-back words.
    cyc(1, 16'hFFFF, 0);
    cap = '0; frc = '0;
    cyc(0, '0, 1);
    cyc(1, 16'h0001, 0);
    for (int i = 1; i < 32; i++) begin
      cyc(0, '0, 0);
      cyc(0, '0, 1);
    end
    chk("b2b_bits", cap[31:0], {ord(16'hFFFF), ord(16'h0001)});
    chk("b2b_frame", frc[31:0], 32'h8000_8000);
    chk("b2b_hempty", {63'd0, hempty}, 64'd1);
    cyc(0, '0, 1);
    chk("b2b_end", {63'd0, busy}, 64'd0);

    // Load coinciding with the final en of the current word.
    cyc(1, 16'h0F0F, 0);
    cap = '0; frc = '0;
    cyc(0, '0, 1);
    cyc(1, 16'h1234, 0);
    repeat (15) cyc(0, '0, 1);
    cyc(1, 16'h5678, 1);
    chk("simul_hold", {61'd0, hempty, ovr, frame}, 64'b001);
    repeat (15) cyc(0, '0, 1);
    repeat (16) cyc(0, '0, 1);
    chk("simul_bits", cap[47:0], {ord(16'h0F0F), ord(16'h1234), ord(16'h5678)});
    chk("simul_frame", frc[47:0], 48'h8000_8000_8000);
    cyc(0, '0, 1);

    // Overrun set, set-beats-clear, clear.
    cyc(1, 16'h1357, 0);
    cyc(1, 16'hDEAD, 0);
    chk("ovr_set", {63'd0, ovr}, 64'd1);
    cyc(1, 16'hBEEF, 0, 1);
    chk("ovr_set_wins", {63'd0, ovr}, 64'd1);
    cyc(0, '0, 0, 1);
    chk("ovr_clear", {63'd0, ovr}, 64'd0);
    cap = '0;
    repeat (16) cyc(0, '0, 1);
    chk("ovr_word_intact", cap[15:0], ord(16'h1357));
    cyc(0, '0, 1);
    chk("ovr_end", {62'd0, busy, hempty}, 64'b01);

    // Reset in the middle of a word with another word held.
    cyc(1, 16'h9999, 0);
    cyc(0, '0, 1);
    cyc(1, 16'h4444, 0);
    repeat (4) cyc(0, '0, 1);
    resl = 1'b0;
    cyc(0, '0, 0);
    resl = 1'b1;
    chk("midreset", {61'd0, busy, sdo, hempty}, 64'b001);
    cyc(1, 16'h8000, 0);
    cyc(0, '0, 1);
    t = ord(16'h8000);
    chk("after_reset_frame", {62'd0, t[W-1], frame}, {62'd0, 1'b1, 1'b1});
    repeat (16) cyc(0, '0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      resl = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 5) == 0, W'($urandom), $urandom_range(0, 2) == 0,
          $urandom_range(0, 15) == 0);
    end
    resl = 1'b1;
    repeat (4) cyc(0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
